sirv_uartrx_core: RTL
=====================

# sirv_uartrx_core

UART receive engine that consumes the serial `io_rxd` line delivered by the UART pad-mux stage (pin input to `io_uart_rxd`). It synchronizes the line, oversamples it at 16x a programmable baud tick, and frames 8N1-style characters with majority-vote sampling. Each received character passes through a one-entry valid/ready holding buffer. It sits between the pad-mux stage and the UART RX FIFO/register block.

## Interface
- `DATA_BITS`, default 8: character width, LSB first; legal values 5–9.
- `DIV_W`, default 16: width of the baud divisor.
- `clock`  input  1  sole clock; all state on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `io_en`  input  1  receiver enable; low forces IDLE.
- `io_rxd`  input  1  raw serial line, idle high, asynchronous to `clock`.
- `io_div`  input  DIV_W  sample tick period minus 1, in clocks.
- `io_out_valid`  output  1  holding buffer holds a character.
- `io_out_ready`  input  1  consumer accepts the character.
- `io_out_bits`  output  DATA_BITS  received character.
- `io_out_ferr`  output  1  framing error (stop bit sampled 0) for `io_out_bits`; qualified by valid.
- `io_overrun`  output  1  one-cycle pulse when a completed character is dropped.

## Operation
- Synchronizer: 2 flops on `io_rxd`, reset to 1. `rxs` is the second flop. All decisions use `rxs`.
- Prescaler: counter 0..`io_div`. A tick is emitted on the cycle the counter equals `io_div`, and the counter then wraps to 0. The prescaler is cleared on IDLE→START.
- Tick counter: 4 bits, 0..15 within each bit, incremented per tick.
  - `rxs` is sampled on ticks with counter value 7, 8 and 9.
  - The bit value is the majority (2 of 3) of those samples, decided on the value-9 tick.
  - The counter wraps 15→0 and advances the bit index.
- FSM states:
  - IDLE: on `io_en` and `rxs`==0 (falling edge relative to the previous `rxs`==1), go to START.
  - START: at decision, if the majority is 1, the start was a glitch: go to IDLE, nothing reported. If 0, go to DATA at wrap.
  - DATA: shift the majority into the shift register LSB first. After bit `DATA_BITS`-1 wraps, go to STOP.
  - STOP: at decision, load the buffer. Set `ferr` = !majority. Go to IDLE immediately, without waiting for ticks 10–15, so back-to-back frames resync.
- In STOP with a 0 stop bit, the line is still low on return to IDLE. A new START requires `rxs` to be seen high first (edge detect), so a break does not generate repeated characters.
- Holding buffer:
  - Load at stop decision when `!io_out_valid`, or when `io_out_valid && io_out_ready` in the same cycle (pop and load together; no overrun).
  - Load when `io_out_valid && !io_out_ready`: the new character is dropped, the buffer is unchanged, and `io_overrun`=1 for one cycle.
  - `io_out_valid` clears the cycle after a handshake with no simultaneous load.
- `io_en` low: FSM goes to IDLE, and the prescaler and tick counters clear within one cycle. The buffer and its handshake stay active.
- A change to `io_div` mid-frame takes effect at the next prescaler compare. Frame timing is unspecified for that frame, but the FSM must not lock up.

## Timing
- Reset values: `io_out_valid`=0, `io_out_bits`=0, `io_out_ferr`=0, `io_overrun`=0, FSM=IDLE, counters=0, shift register=0, sync flops=1.
- Input latency: 2 cycles from `io_rxd` to `rxs`.
- Edge cycle E is the first cycle `rxs`==0 in IDLE. The prescaler clears in E, so tick k (k≥0, frame-global) occurs at cycle E+1+(k+1)(`io_div`+1)−1.
  - With `io_div`=0: one tick per clock.
  - Start decision occurs 10 ticks after E.
  - The frame's final decision occurs at tick 16·(`DATA_BITS`+1)+9.
- `io_out_valid`/`io_out_bits`/`io_out_ferr` are registered: they are visible the cycle after the stop decision tick. `io_overrun` pulses in that same cycle.
- `io_out_valid` has no combinational path from `io_out_ready`.
- Reset asserted mid-frame aborts immediately. Outputs take reset values asynchronously, and a partial character is never delivered.

## Test plan
- `io_div`=3, send 0xA5 with stop=1, `io_out_ready`=1 → one valid cycle with bits=0xA5, ferr=0, overrun=0; valid asserted 4·(16·9+9)+O(3) cycles after the line falls.
- Glitch: `io_rxd` low for 3 ticks then high, `io_div`=0 → no valid, FSM back in IDLE; a following 0x3C frame is received correctly.
- Stop bit 0 with character 0x00 and the line held low for 40 bit times → exactly one character 0x00 with ferr=1; no further characters until the line returns high and a new start arrives.
- `io_out_ready`=0, two frames 0x11 then 0x22 → buffer holds 0x11, overrun pulses once at the 0x22 stop decision; raise ready → 0x11 popped, valid drops.
- Ready asserted on exactly the cycle the second character completes → 0x11 consumed, 0x22 loaded, valid stays 1, no overrun.
- Assert `reset` mid-DATA, and separately drop `io_en` mid-DATA → no partial character delivered; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/sirv_uartrx_core.sv
// UART receive engine: 2-flop line sync, 16x oversampling with 2-of-3 majority
// per bit, 8N1-style framing, and a one-entry valid/ready holding buffer.
module sirv_uartrx_core #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_en,
  input  logic                 io_rxd,
  input  logic [DIV_W-1:0]     io_div,
  output logic                 io_out_valid,
  input  logic                 io_out_ready,
  output logic [DATA_BITS-1:0] io_out_bits,
  output logic                 io_out_ferr,
  output logic                 io_overrun
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS-1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nxt;

  logic                 sync0, rxs, rxs_q;
  logic [DIV_W-1:0]     pres;
  logic [3:0]           tcnt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 s7, s8;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick, decide, wrap, maj, fall;
  logic                 clr, shift_en, load_req;

  // >= rather than == so a divisor lowered mid-frame cannot strand the counter
  assign tick   = (pres >= io_div);
  assign decide = tick && (tcnt == 4'd9);
  assign wrap   = tick && (tcnt == 4'd15);
  assign maj    = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  // rxs_q gates the start so a held-low line (break) cannot retrigger
  assign fall   = io_en && rxs_q && !rxs;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync0 <= 1'b1;
      rxs   <= 1'b1;
      rxs_q <= 1'b1;
    end else begin
      sync0 <= io_rxd;
      rxs   <= sync0;
      rxs_q <= rxs;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!io_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (fall) state_nxt = START;
        START:   if (decide && maj) state_nxt = IDLE;
                 else if (wrap)     state_nxt = DATA;
        DATA:    if (wrap && bit_idx == LAST_IDX) state_nxt = STOP;
        STOP:    if (decide) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    clr      = (state == IDLE) || !io_en;
    shift_en = io_en && (state == DATA) && decide;
    load_req = io_en && (state == STOP) && decide;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pres    <= '0;
      tcnt    <= '0;
      bit_idx <= '0;
      s7      <= 1'b0;
      s8      <= 1'b0;
    end else if (clr) begin
      pres    <= '0;
      tcnt    <= '0;
      bit_idx <= '0;
    end else if (tick) begin
      pres <= '0;
      tcnt <= tcnt + 4'd1;
      if (tcnt == 4'd7) s7 <= rxs;
      if (tcnt == 4'd8) s8 <= rxs;
      if (tcnt == 4'd15 && state == DATA) bit_idx <= bit_idx + IDX_W'(1);
    end else begin
      pres <= pres + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)         shreg <= '0;
    else if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
  end

  // Pop and load in the same cycle is a plain replacement, not an overrun
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_out_valid <= 1'b0;
      io_out_bits  <= '0;
      io_out_ferr  <= 1'b0;
      io_overrun   <= 1'b0;
    end else begin
      io_overrun <= 1'b0;
      if (load_req) begin
        if (!io_out_valid || io_out_ready) begin
          io_out_valid <= 1'b1;
          io_out_bits  <= shreg;
          io_out_ferr  <= !maj;
        end else begin
          io_overrun <= 1'b1;
        end
      end else if (io_out_valid && io_out_ready) begin
        io_out_valid <= 1'b0;
      end
    end
  end

endmodule
